// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - writeback arbiter for the register-file write port with RAW scoreboard
//
// Shares one register-file write port among NREQ writeback sources and keeps
// a per-register pending-write scoreboard for issue-stage hazard stalls.
//
// Build option: define WB_RR_ARB_EN for round-robin arbitration; otherwise
// fixed priority (index 0 highest) and no pointer register exists.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   src_valid/reg/data writeback requests, packed per source
//   src_ready          one-hot grant, combinational
//   rf_wr/wr_reg/wr_data registered register-file write port
//   claim_valid/reg    issue stage reserves a destination register
//   flush              clears the scoreboard, blocks grants
//   rd_reg1/2, busy1/2 hazard lookup for two source operands
//   sb_err             sticky scoreboard protocol error

module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      src_valid,
    input  logic [NREQ*AW-1:0]   src_reg,
    input  logic [NREQ*DW-1:0]   src_data,
    output logic [NREQ-1:0]      src_ready,
    output logic                 rf_wr,
    output logic [AW-1:0]        wr_reg,
    output logic [DW-1:0]        wr_data,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_reg,
    input  logic                 flush,
    input  logic [AW-1:0]        rd_reg1,
    input  logic [AW-1:0]        rd_reg2,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 sb_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NR = 1 << AW;

    logic [AW-1:0] reg_a  [NREQ];
    logic [DW-1:0] data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reg_a[i]  = src_reg[i*AW +: AW];
        assign data_a[i] = src_data[i*DW +: DW];
    end

    logic [IW-1:0]   gidx;
    logic            found;
    logic [NREQ-1:0] grant;

`ifdef WB_RR_ARB_EN
    logic [IW-1:0] ptr;

    // Scan offsets from the highest down so the smallest offset from the
    // pointer is the last assignment and therefore wins.
    always_comb begin
        logic [IW:0] sum;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        if (rst && !flush) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                sum = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                if (src_valid[sum[IW-1:0]]) begin
                    gidx  = sum[IW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end
`else
    // Descending scan: the lowest valid index is assigned last and wins.
    always_comb begin
        gidx  = '0;
        found = 1'b0;
        if (rst && !flush) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (src_valid[IW'(k)]) begin
                    gidx  = IW'(k);
                    found = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign src_ready = grant;

    // Output stage never back-pressures: a grant always loads it. Writes to
    // register 0 consume the grant but do not assert rf_wr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wr   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (found) begin
            rf_wr   <= (reg_a[gidx] != '0);
            wr_reg  <= reg_a[gidx];
            wr_data <= data_a[gidx];
        end else begin
            rf_wr   <= 1'b0;
        end
    end

    logic [NR-1:0] busy;
    logic [NR-1:0] busy_next;
    logic          claim;
    logic          retire;
    logic          claim_err;
    logic          retire_err;

    assign claim      = claim_valid && (claim_reg != '0) && !flush;
    assign retire     = rf_wr && (wr_reg != '0);
    // A claim on a register retiring at this very edge is a legal reuse.
    assign claim_err  = claim && busy[claim_reg] && !(rf_wr && (wr_reg == claim_reg));
    assign retire_err = retire && !busy[wr_reg];

    // Clear before set so a same-edge claim of the retiring register wins.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (rf_wr) begin
                busy_next[wr_reg] = 1'b0;
            end
            if (claim) begin
                busy_next[claim_reg] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy   <= busy_next;
            sb_err <= sb_err | claim_err | retire_err;
        end
    end

    assign busy1 = busy[rd_reg1];
    assign busy2 = busy[rd_reg2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard testbench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     src_valid;
    logic [NREQ*AW-1:0]  src_reg;
    logic [NREQ*DW-1:0]  src_data;
    logic [NREQ-1:0]     src_ready;
    logic                rf_wr;
    logic [AW-1:0]       wr_reg;
    logic [DW-1:0]       wr_data;
    logic                claim_valid;
    logic [AW-1:0]       claim_reg;
    logic                flush;
    logic [AW-1:0]       rd_reg1;
    logic [AW-1:0]       rd_reg2;
    logic                busy1;
    logic                busy2;
    logic                sb_err;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_reg(src_reg), .src_data(src_data),
        .src_ready(src_ready),
        .rf_wr(rf_wr), .wr_reg(wr_reg), .wr_data(wr_data),
        .claim_valid(claim_valid), .claim_reg(claim_reg), .flush(flush),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        src_reg[i*AW +: AW]  = r;
        src_data[i*DW +: DW] = d;
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && rf_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %0h expected none", wr_reg, wr_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wb_write", {27'd0, wr_reg, wr_data}, {27'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b0; src_valid = '0; src_reg = '0; src_data = '0;
        claim_valid = 1'b0; claim_reg = '0; flush = 1'b0;
        rd_reg1 = '0; rd_reg2 = '0;
        tick(); tick();
        rst = 1'b1;
        smp();
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", {busy1, busy2}, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_ready", src_ready, 0);

        // Single write to reg 5 from source 1
        tick();
        claim_valid = 1'b1; claim_reg = 5'd5; rd_reg1 = 5'd5;
        smp();
        chk("sw_busy_pre", busy1, 0);
        tick();
        claim_valid = 1'b0;
        src_valid = 3'b010; set_src(1, 5'd5, 32'hDEAD_BEEF);
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        smp();
        chk("sw_ready", src_ready, 3'b010);
        chk("sw_busy_set", busy1, 1);
        tick();
        src_valid = '0;
        smp();
        chk("sw_rf_wr", rf_wr, 1);
        chk("sw_busy_hold", busy1, 1);
        tick();
        smp();
        chk("sw_busy_clr", busy1, 0);
        chk("sw_rf_wr_off", rf_wr, 0);

        // Granted write to register 0: grant consumed, no write, no error
        tick();
        src_valid = 3'b001; set_src(0, 5'd0, 32'h1234);
        smp();
        chk("r0_ready", src_ready, 3'b001);
        tick();
        src_valid = '0;
        smp();
        chk("r0_rf_wr", rf_wr, 0);
        chk("r0_wr_reg", wr_reg, 0);
        chk("r0_sb_err", sb_err, 0);

`ifdef WB_RR_ARB_EN
        // Pointer is now 1; all sources held valid, all targeting reg 0
        tick();
        set_src(0, 5'd0, 32'hA0); set_src(1, 5'd0, 32'hA1); set_src(2, 5'd0, 32'hA2);
        src_valid = 3'b111;
        smp(); chk("rr_g0", src_ready, 3'b010);
        tick(); smp(); chk("rr_g1", src_ready, 3'b100);
        tick(); smp(); chk("rr_g2", src_ready, 3'b001);
        tick(); smp(); chk("rr_g3", src_ready, 3'b010);
        tick();
        src_valid = '0;
        smp();
        chk("rr_rf_wr", rf_wr, 0);
`else
        // Claim 10, 11, 12 then contend with all three sources
        for (int i = 0; i < 3; i++) begin
            tick();
            claim_valid = 1'b1; claim_reg = AW'(10 + i);
        end
        tick();
        claim_valid = 1'b0;
        set_src(0, 5'd10, 32'hA0); set_src(1, 5'd11, 32'hA1); set_src(2, 5'd12, 32'hA2);
        src_valid = 3'b111;
        exp_q.push_back({5'd10, 32'hA0});
        smp(); chk("fp_g0", src_ready, 3'b001);
        tick();
        src_valid = 3'b110;
        exp_q.push_back({5'd11, 32'hA1});
        smp(); chk("fp_g1", src_ready, 3'b010); chk("fp_wr0", rf_wr, 1);
        tick();
        src_valid = 3'b100;
        exp_q.push_back({5'd12, 32'hA2});
        smp(); chk("fp_g2", src_ready, 3'b100); chk("fp_wr1", rf_wr, 1);
        tick();
        src_valid = '0;
        smp(); chk("fp_wr2", rf_wr, 1);
        tick();
        smp(); chk("fp_sb_err", sb_err, 0);
`endif

        // Flush clears claims on 3 and 4 and blocks grants
        tick();
        claim_valid = 1'b1; claim_reg = 5'd3; rd_reg1 = 5'd3; rd_reg2 = 5'd4;
        tick();
        claim_reg = 5'd4;
        tick();
        claim_valid = 1'b0;
        flush = 1'b1; src_valid = 3'b001; set_src(0, 5'd3, 32'h33);
        smp();
        chk("fl_ready", src_ready, 0);
        chk("fl_busy_pre", {busy1, busy2}, 2'b11);
        tick();
        flush = 1'b0; src_valid = '0;
        smp();
        chk("fl_busy_post", {busy1, busy2}, 2'b00);
        chk("fl_rf_wr", rf_wr, 0);

        // Claim of reg 6 on the edge it retires: set wins, no error
        tick();
        claim_valid = 1'b1; claim_reg = 5'd6; rd_reg1 = 5'd6;
        tick();
        claim_valid = 1'b0;
        src_valid = 3'b010; set_src(1, 5'd6, 32'h66);
        exp_q.push_back({5'd6, 32'h66});
        smp(); chk("col_ready", src_ready, 3'b010);
        tick();
        src_valid = '0;
        claim_valid = 1'b1; claim_reg = 5'd6;
        smp(); chk("col_rf_wr", rf_wr, 1);
        tick();
        claim_valid = 1'b0;
        smp();
        chk("col_busy", busy1, 1);
        chk("col_sb_err", sb_err, 0);

        // Double claim of reg 7
        tick();
        claim_valid = 1'b1; claim_reg = 5'd7;
        tick();
        smp(); chk("dc_sb_err_first", sb_err, 0);
        tick();
        claim_valid = 1'b0;
        smp(); chk("dc_sb_err", sb_err, 1);

        // Reset, then retire reg 9 that was never claimed
        tick();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        smp(); chk("rr_sb_err_rst", sb_err, 0);
        tick();
        src_valid = 3'b100; set_src(2, 5'd9, 32'h99);
        exp_q.push_back({5'd9, 32'h99});
        smp(); chk("ur_ready", src_ready, 3'b100);
        tick();
        src_valid = '0;
        smp(); chk("ur_rf_wr", rf_wr, 1);
        tick();
        smp(); chk("ur_sb_err", sb_err, 1);

        tick(); tick();
        smp();
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
